// File: rtl/mnist_pkg.sv
// -----------------------------------------------------------------------------
// mnist_pkg
// Shared types and constants for the MNIST inference pipeline.
//   NUM_CLASSES  : number of output classes of the final dense layer.
//   FEATURE_W    : bit width of one feature value.
//   feature_type : signed two's-complement feature value.
// -----------------------------------------------------------------------------
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int FEATURE_W   = 8;

    typedef logic signed [FEATURE_W-1:0] feature_type;

endpackage : mnist_pkg

// File: rtl/feature_if.sv
// -----------------------------------------------------------------------------
// feature_if
// Valid/ready stream carrying NUM_FEATURES signed features per beat.
//   valid    : source presents a beat.
//   ready    : sink accepts; a beat moves on a clock edge with valid && ready.
//   features : lane i of beat b is vector element b*NUM_FEATURES + i.
// -----------------------------------------------------------------------------
interface feature_if
    import mnist_pkg::*;
#(
    parameter int NUM_FEATURES = 2
);
    logic        valid;
    logic        ready;
    feature_type features [NUM_FEATURES];

    modport source (output valid, output features, input ready);
    modport sink   (input valid, input features, output ready);
endinterface : feature_if

// File: rtl/argmax_lane_max.sv
// -----------------------------------------------------------------------------
// argmax_lane_max
// Combinational reduction of one beat into the running maximum.
//   best_val_i/best_idx_i : running best before this beat.
//   lanes_i               : feature lanes of the beat.
//   base_idx_i            : element index of lane 0.
//   lane_en_i             : lanes that hold real vector elements.
//   first_i               : beat 0; lane 0 loads unconditionally.
//   best_val_o/best_idx_o : running best after this beat.
// Lanes are visited in ascending order and only a strictly greater value
// replaces the best, so ties keep the lowest element index.
// -----------------------------------------------------------------------------
module argmax_lane_max
    import mnist_pkg::*;
#(
    parameter int NUM_FEATURES = 2,
    parameter int IDX_W        = 4
) (
    input  feature_type             best_val_i,
    input  logic [IDX_W-1:0]        best_idx_i,
    input  feature_type             lanes_i [NUM_FEATURES],
    input  logic [IDX_W-1:0]        base_idx_i,
    input  logic [NUM_FEATURES-1:0] lane_en_i,
    input  logic                    first_i,
    output feature_type             best_val_o,
    output logic [IDX_W-1:0]        best_idx_o
);

    always_comb begin
        feature_type      val_v;
        logic [IDX_W-1:0] idx_v;
        val_v = best_val_i;
        idx_v = best_idx_i;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            // Element 0 seeds the search; there is no sentinel minimum.
            if (lane_en_i[i] && (((i == 0) && first_i) || (lanes_i[i] > val_v))) begin
                val_v = lanes_i[i];
                idx_v = base_idx_i + IDX_W'(i);
            end
        end
        best_val_o = val_v;
        best_idx_o = idx_v;
    end

endmodule : argmax_lane_max

// File: rtl/argmax_sink.sv
// -----------------------------------------------------------------------------
// argmax_sink
// Terminal consumer of the final dense layer output. Receives one vector of
// VECTOR_LENGTH signed features over BEATS beats, finds the maximum and its
// index, and offers them on a valid/ready result port.
//   clock, reset_n : clock and asynchronous active-low reset.
//   features_in    : feature stream, sink side (ready high while receiving).
//   class_valid    : result available.
//   class_ready    : result consumer accepts.
//   class_index    : index of the maximum feature.
//   class_score    : value of the maximum feature.
//   vector_count   : results handed off since reset, wraps at 2^16.
// -----------------------------------------------------------------------------
module argmax_sink
    import mnist_pkg::*;
#(
    parameter  int VECTOR_LENGTH = NUM_CLASSES,
    parameter  int NUM_FEATURES  = 2,
    localparam int IDX_W         = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    feature_if.sink          features_in,
    output logic             class_valid,
    input  logic             class_ready,
    output logic [IDX_W-1:0] class_index,
    output feature_type      class_score,
    output logic [15:0]      vector_count
);

    localparam int BEATS  = (VECTOR_LENGTH + NUM_FEATURES - 1) / NUM_FEATURES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        S_RECV = 1'b0,
        S_HOLD = 1'b1
    } argmax_state_type;

    argmax_state_type  state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    feature_type       best_val_q, best_val_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    feature_type       result_val_q, result_val_d;
    logic [IDX_W-1:0]  result_idx_q, result_idx_d;
    logic [15:0]       count_q, count_d;

    feature_type             lane_val [NUM_FEATURES];
    logic [NUM_FEATURES-1:0] lane_en;
    logic [31:0]             base_elem;
    feature_type             red_val;
    logic [IDX_W-1:0]        red_idx;
    logic                    xfer;
    logic                    handoff;

    assign xfer    = features_in.valid && (state_q == S_RECV);
    assign handoff = (state_q == S_HOLD) && class_ready;

    // Element index of lane 0 in the current beat; kept wide so the
    // out-of-range test for the partial last beat cannot wrap.
    assign base_elem = 32'(beat_q) * 32'(NUM_FEATURES);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FEATURES; gi++) begin : g_lane
            assign lane_val[gi] = features_in.features[gi];
            assign lane_en[gi]  = (base_elem + 32'(gi)) < 32'(VECTOR_LENGTH);
        end
    endgenerate

    argmax_lane_max #(
        .NUM_FEATURES (NUM_FEATURES),
        .IDX_W        (IDX_W)
    ) u_lane_max (
        .best_val_i (best_val_q),
        .best_idx_i (best_idx_q),
        .lanes_i    (lane_val),
        .base_idx_i (base_elem[IDX_W-1:0]),
        .lane_en_i  (lane_en),
        .first_i    (beat_q == '0),
        .best_val_o (red_val),
        .best_idx_o (red_idx)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        result_val_d = result_val_q;
        result_idx_d = result_idx_q;
        count_d      = count_q;

        if (xfer) begin
            best_val_d = red_val;
            best_idx_d = red_idx;
            if (beat_q == LAST_BEAT) begin
                // Result registers only change here, so the outputs stay
                // stable while the result is being held.
                state_d      = S_HOLD;
                result_val_d = red_val;
                result_idx_d = red_idx;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        if (handoff) begin
            state_d = S_RECV;
            beat_d  = '0;
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RECV;
            beat_q       <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            result_val_q <= '0;
            result_idx_q <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            result_val_q <= result_val_d;
            result_idx_q <= result_idx_d;
            count_q      <= count_d;
        end
    end

    assign features_in.ready = (state_q == S_RECV);
    assign class_valid       = (state_q == S_HOLD);
    assign class_index       = result_idx_q;
    assign class_score       = result_val_q;
    assign vector_count      = count_q;

endmodule : argmax_sink
